// File: rtl/mm_host_pkg.sv
// Shared types and constants for the multiplier host sequencer: state encoding,
// mode-line encodings, register selects and the registered output bundle.
package mm_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_LD,
        ST_MM,
        ST_RD,
        ST_ERR
    } state_t;

    // Mode lines are {load, write}
    localparam logic [1:0] MODE_WRITE  = 2'b01;
    localparam logic [1:0] MODE_LOAD   = 2'b10;
    localparam logic [1:0] MODE_MATMUL = 2'b00;
    localparam logic [1:0] MODE_READ   = 2'b11;

    localparam logic [2:0] REG_A = 3'd0;
    localparam logic [2:0] REG_B = 3'd1;
    localparam logic [2:0] REG_C = 3'd2;

    localparam int OPERAND_COUNT = 8;
    localparam int RESULT_COUNT  = 4;

    typedef struct packed {
        logic       en;
        logic [1:0] mode;
        logic [7:0] data_in;
        logic [1:0] idx;
        logic [2:0] reg_select;
        logic       op_ready;
        logic [7:0] res_data;
        logic       res_valid;
        logic       busy;
        logic       done;
        logic       err;
    } host_out_t;

    localparam host_out_t OUT_RESET = '{
        en:         1'b0,
        mode:       MODE_WRITE,
        data_in:    8'd0,
        idx:        2'd0,
        reg_select: 3'd0,
        op_ready:   1'b0,
        res_data:   8'd0,
        res_valid:  1'b0,
        busy:       1'b0,
        done:       1'b0,
        err:        1'b0
    };

    function automatic logic [2:0] operand_reg(input logic [3:0] n);
        return (n < 4'd4) ? REG_A : REG_B;
    endfunction

endpackage

// File: rtl/int_edge_watchdog.sv
// Rising-edge detector on the FSM interrupt plus a clearable watchdog counter
// that flags when TIMEOUT_CYCLES enabled cycles pass without an edge.
module int_edge_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic clear,
    input  logic enable,
    output logic rise,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             int_q;
    logic [CNT_W-1:0] cnt;

    assign rise    = irq && !int_q;
    assign expired = enable && (cnt == TERMINAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_q <= 1'b0;
            cnt   <= '0;
        end else begin
            int_q <= irq;
            // Counter parks at terminal count; the sequencer leaves the wait state then
            if (clear) begin
                cnt <= '0;
            end else if (enable && (cnt != TERMINAL)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mm_host_sequencer.sv
// Host-side initiator that writes both operand matrices into the multiplier FSM,
// runs load and matmul, then streams the four result bytes out with a handshake.
module mm_host_sequencer
    import mm_host_pkg::*;
#(
    parameter int READ_LAT       = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] op_data,
    input  logic       op_valid,
    output logic       op_ready,
    output logic [7:0] res_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       mm_en,
    output logic       mm_write,
    output logic       mm_load,
    output logic [7:0] mm_data_in,
    output logic [1:0] mm_idx,
    output logic [2:0] mm_reg_select,
    input  logic       mm_int,
    input  logic [7:0] mm_data_out
);

    localparam int LAT_W = $clog2(READ_LAT + 1) + 1;

    state_t          state, state_n;
    host_out_t       outs, outs_n;
    logic [3:0]      op_cnt, op_cnt_n;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_n;

    logic wd_clear, wd_enable, int_rise, wd_expired;

    int_edge_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .irq    (mm_int),
        .clear  (wd_clear),
        .enable (wd_enable),
        .rise   (int_rise),
        .expired(wd_expired)
    );

    assign wd_enable = (state == ST_LD) || (state == ST_MM);
    assign wd_clear  = (state_n != state) && ((state_n == ST_LD) || (state_n == ST_MM));

    // Returning to IDLE keeps the last result byte but restores every other output
    function automatic host_out_t idle_outputs(input host_out_t cur);
        host_out_t o;
        o          = OUT_RESET;
        o.res_data = cur.res_data;
        return o;
    endfunction

    always_comb begin
        state_n     = state;
        outs_n      = outs;
        outs_n.done = 1'b0;
        outs_n.err  = 1'b0;
        op_cnt_n    = op_cnt;
        lat_cnt_n   = lat_cnt;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n         = ST_WR;
                    op_cnt_n        = '0;
                    outs_n.en       = 1'b1;
                    outs_n.mode     = MODE_WRITE;
                    outs_n.op_ready = 1'b1;
                    outs_n.busy     = 1'b1;
                end
            end

            // After the last byte is accepted, op_ready drops and one more cycle presents it
            ST_WR: begin
                if (outs.op_ready && op_valid) begin
                    outs_n.reg_select = operand_reg(op_cnt);
                    outs_n.idx        = op_cnt[1:0];
                    outs_n.data_in    = op_data;
                    op_cnt_n          = op_cnt + 4'd1;
                    if (op_cnt == 4'(OPERAND_COUNT - 1)) begin
                        outs_n.op_ready = 1'b0;
                    end
                end else if (!outs.op_ready) begin
                    state_n     = ST_LD;
                    outs_n.mode = MODE_LOAD;
                end
            end

            ST_LD: begin
                if (int_rise) begin
                    state_n     = ST_MM;
                    outs_n.mode = MODE_MATMUL;
                end else if (wd_expired) begin
                    state_n    = ST_ERR;
                    outs_n.en  = 1'b0;
                    outs_n.err = 1'b1;
                end
            end

            ST_MM: begin
                if (int_rise) begin
                    state_n           = ST_RD;
                    outs_n.mode       = MODE_READ;
                    outs_n.reg_select = REG_C;
                    outs_n.idx        = 2'd0;
                    lat_cnt_n         = '0;
                end else if (wd_expired) begin
                    state_n    = ST_ERR;
                    outs_n.en  = 1'b0;
                    outs_n.err = 1'b1;
                end
            end

            ST_RD: begin
                if (!outs.res_valid) begin
                    if (lat_cnt == LAT_W'(READ_LAT)) begin
                        outs_n.res_data  = mm_data_out;
                        outs_n.res_valid = 1'b1;
                    end else begin
                        lat_cnt_n = lat_cnt + 1'b1;
                    end
                end else if (res_ready) begin
                    outs_n.res_valid = 1'b0;
                    if (outs.idx == 2'(RESULT_COUNT - 1)) begin
                        state_n     = ST_IDLE;
                        outs_n      = idle_outputs(outs);
                        outs_n.done = 1'b1;
                    end else begin
                        outs_n.idx = outs.idx + 2'd1;
                        lat_cnt_n  = '0;
                    end
                end
            end

            ST_ERR: begin
                state_n = ST_IDLE;
                outs_n  = idle_outputs(outs);
            end

            default: begin
                state_n = ST_IDLE;
                outs_n  = idle_outputs(outs);
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            outs    <= OUT_RESET;
            op_cnt  <= '0;
            lat_cnt <= '0;
        end else begin
            state   <= state_n;
            outs    <= outs_n;
            op_cnt  <= op_cnt_n;
            lat_cnt <= lat_cnt_n;
        end
    end

    assign op_ready      = outs.op_ready;
    assign res_data      = outs.res_data;
    assign res_valid     = outs.res_valid;
    assign busy          = outs.busy;
    assign done          = outs.done;
    assign err           = outs.err;
    assign mm_en         = outs.en;
    assign mm_load       = outs.mode[1];
    assign mm_write      = outs.mode[0];
    assign mm_data_in    = outs.data_in;
    assign mm_idx        = outs.idx;
    assign mm_reg_select = outs.reg_select;

endmodule
